// File: rtl/fixed_to_float_convert.sv
// fixed_to_float_convert
// Sequential converter from a signed two's-complement fixed-point value
// (FIXED / 2^FRAC) to an IEEE-754 single-precision word. The magnitude is
// normalised one bit per cycle, rounded to nearest-even and packed.
//
// Ports:
//   CLK           system clock, rising edge
//   RST_FF        asynchronous active-low reset
//   Begin_FSM_FX  start request (level), held until ACK_FX is seen
//   FIXED[W-1:0]  signed fixed-point input, sampled only on the start edge
//   FLOAT[31:0]   packed result {sign, exp[7:0], mant[22:0]}, registered
//   ACK_FX        result valid / conversion done
//   BUSY          high whenever the converter is not idle
module fixed_to_float_convert #(
    parameter int W    = 32,
    parameter int FRAC = 26
) (
    input  logic         CLK,
    input  logic         RST_FF,
    input  logic         Begin_FSM_FX,
    input  logic [W-1:0] FIXED,
    output logic [31:0]  FLOAT,
    output logic         ACK_FX,
    output logic         BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Biased exponent of a value whose leading one sits in bit W-1.
    localparam logic [8:0]   EXP_INIT    = 9'(127 + W - 1 - FRAC);
    // Bits below the guard bit; empty when W = 25.
    localparam logic [W-1:0] STICKY_MASK = (W'(1) << (W - 25)) - W'(1);

    // Round-to-nearest-even on a 23-bit mantissa; bit 23 of the result is
    // the carry out that bumps the exponent (mantissa bits are then zero).
    function automatic logic [23:0] round_mant(input logic [22:0] mant,
                                               input logic        guard,
                                               input logic        sticky);
        logic inc;
        inc = guard & (sticky | mant[0]);
        return {1'b0, mant} + {23'd0, inc};
    endfunction

    state_t        state_q, state_d;
    logic          sign_q,  sign_d;
    logic [W-1:0]  mag_q,   mag_d;
    logic [8:0]    exp_q,   exp_d;
    logic [31:0]   float_q, float_d;
    logic          ack_q,   ack_d;
    logic          busy_q,  busy_d;
    logic [23:0]   rnd_s;
    logic [8:0]    exp_rnd_s;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        float_d   = float_q;
        rnd_s     = round_mant(mag_q[W-2 -: 23], mag_q[W-25],
                               |(mag_q & STICKY_MASK));
        exp_rnd_s = exp_q + {8'd0, rnd_s[23]};

        case (state_q)
            IDLE: begin
                if (Begin_FSM_FX) begin
                    sign_d  = FIXED[W-1];
                    // Negation of the most negative value wraps to 2^(W-1),
                    // which is exactly its magnitude as an unsigned number.
                    mag_d   = FIXED[W-1] ? (~FIXED + W'(1)) : FIXED;
                    exp_d   = EXP_INIT;
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                // A zero magnitude also moves on; ROUND then emits +0, which
                // puts the zero result two edges after the start.
                if ((mag_q == '0) || mag_q[W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 9'd1;
                end
            end
            ROUND: begin
                if (mag_q == '0) begin
                    float_d = 32'h0000_0000;
                end else begin
                    float_d = {sign_q, exp_rnd_s[7:0], rnd_s[22:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (!Begin_FSM_FX) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= 9'd0;
            float_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            float_q <= float_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign FLOAT  = float_q;
    assign ACK_FX = ack_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_fixed_to_float_convert.sv
// Self-checking bench for fixed_to_float_convert (W=32, FRAC=26).
// Reference: the input is turned into a real number, its double-precision
// encoding is re-rounded to single precision (nearest-even), and latency is
// derived from the value's binary exponent.
module tb_fixed_to_float_convert;

    localparam int W    = 32;
    localparam int FRAC = 26;

    logic          CLK = 1'b0;
    logic          RST_FF = 1'b0;
    logic          Begin_FSM_FX = 1'b0;
    logic [W-1:0]  FIXED = '0;
    logic [31:0]   FLOAT;
    logic          ACK_FX;
    logic          BUSY;

    int errors = 0;
    int checks = 0;

    fixed_to_float_convert #(.W(W), .FRAC(FRAC)) dut (
        .CLK(CLK), .RST_FF(RST_FF), .Begin_FSM_FX(Begin_FSM_FX),
        .FIXED(FIXED), .FLOAT(FLOAT), .ACK_FX(ACK_FX), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Value = FIXED / 2^FRAC, exact in a double; re-round double to single.
    function automatic logic [31:0] ref_float(input logic [31:0] fx);
        real         v;
        logic [63:0] b;
        int          e;
        logic [23:0] r;
        logic        g, s;
        if (fx == 32'd0) return 32'h0000_0000;
        v = $itor($signed(fx)) / (2.0 ** FRAC);
        b = $realtobits(v);
        e = int'(b[62:52]) - 1023 + 127;
        g = b[28];
        s = |b[27:0];
        r = {1'b0, b[51:29]} + {23'd0, (g & (s | b[29]))};
        if (r[23]) begin
            e = e + 1;
            r = 24'd0;
        end
        return {b[63], e[7:0], r[22:0]};
    endfunction

    // Cycles from the start edge to ACK: leading zeros of |FIXED| plus 2.
    function automatic int ref_lat(input logic [31:0] fx);
        real         v;
        logic [63:0] b;
        int          e;
        if (fx == 32'd0) return 2;
        v = $itor($signed(fx)) / (2.0 ** FRAC);
        b = $realtobits(v);
        e = int'(b[62:52]) - 1023;       // floor(log2 |value|)
        return (W - 1) - (e + FRAC) + 2;
    endfunction

    // Transaction-level model of the observable outputs.
    logic        m_busy = 1'b0, m_ack = 1'b0;
    logic [31:0] m_float = 32'd0, m_next = 32'd0;
    int          m_left = 0;

    always @(posedge CLK or negedge RST_FF) begin
        if (!RST_FF) begin
            m_busy = 1'b0; m_ack = 1'b0; m_float = 32'd0; m_left = 0;
        end else if (!m_busy) begin
            if (Begin_FSM_FX) begin
                m_busy = 1'b1;
                m_left = ref_lat(FIXED);
                m_next = ref_float(FIXED);
            end
        end else if (!m_ack) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_ack   = 1'b1;
                m_float = m_next;
            end
        end else if (!Begin_FSM_FX) begin
            m_ack  = 1'b0;
            m_busy = 1'b0;
        end
    end

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge CLK) begin
        if (RST_FF) begin
            chk("mon_busy",  {63'd0, BUSY},   {63'd0, m_busy});
            chk("mon_ack",   {63'd0, ACK_FX}, {63'd0, m_ack});
            chk("mon_float", {32'd0, FLOAT},  {32'd0, m_float});
        end
    end

    // One conversion. mode 0: request dropped right after the start edge;
    // mode 1: request held through DONE for a few cycles.
    task automatic conv(input logic [31:0] fx, input logic [31:0] want,
                        input int want_lat, input int mode);
        int k;
        @(negedge CLK);
        FIXED = fx;
        Begin_FSM_FX = 1'b1;
        @(posedge CLK);
        #1 chk("busy_t0", {63'd0, BUSY}, 64'd1);
        @(negedge CLK);
        FIXED = $urandom;                 // must be ignored
        if (mode == 0) Begin_FSM_FX = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (ACK_FX) break;
        end
        chk("latency", 64'(k), 64'(want_lat));
        chk("float", {32'd0, FLOAT}, {32'd0, want});
        if (mode == 0) begin
            @(posedge CLK);
            #1 chk("ack_pulse", {63'd0, ACK_FX}, 64'd0);
        end else begin
            repeat (3) begin
                @(posedge CLK);
                #1 chk("ack_hold", {63'd0, ACK_FX}, 64'd1);
            end
            @(negedge CLK);
            Begin_FSM_FX = 1'b0;
            @(posedge CLK);
            #1 chk("idle_after_drop", {62'd0, ACK_FX, BUSY}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] fx;

        // Model pins against hand-computed values.
        chk("ref_one",   {32'd0, ref_float(32'h0400_0000)}, {32'd0, 32'h3F80_0000});
        chk("ref_neg",   {32'd0, ref_float(32'hFA00_0000)}, {32'd0, 32'hBFC0_0000});
        chk("ref_even",  {32'd0, ref_float(32'h4000_00C0)}, {32'd0, 32'h4180_0002});
        chk("ref_carry", {32'd0, ref_float(32'h7FFF_FFFF)}, {32'd0, 32'h4200_0000});
        chk("ref_lat1",  64'(ref_lat(32'h0000_0001)), 64'd33);
        chk("ref_latn",  64'(ref_lat(32'h8000_0000)), 64'd2);

        repeat (3) @(posedge CLK);
        #1 chk("reset_out", {31'd0, FLOAT, ACK_FX, BUSY}, 64'd0);
        @(negedge CLK);
        RST_FF = 1'b1;

        conv(32'h0400_0000, 32'h3F80_0000, 7, 0);
        conv(32'hFA00_0000, 32'hBFC0_0000, 7, 1);
        conv(32'h8000_0000, 32'hC200_0000, 2, 0);
        conv(32'h0000_0001, 32'h3280_0000, 33, 1);
        conv(32'h0000_0000, 32'h0000_0000, 2, 0);
        conv(32'h4000_0040, 32'h4180_0000, 3, 0);
        conv(32'h4000_00C0, 32'h4180_0002, 3, 1);
        conv(32'h7FFF_FFFF, 32'h4200_0000, 3, 0);

        // Reset during normalisation of FIXED = 1.
        @(negedge CLK);
        FIXED = 32'h0000_0001;
        Begin_FSM_FX = 1'b1;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        #2;
        RST_FF = 1'b0;
        Begin_FSM_FX = 1'b0;
        #1 chk("reset_mid", {31'd0, FLOAT, ACK_FX, BUSY}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_FF = 1'b1;
        repeat (5) @(posedge CLK);
        #1 chk("no_ack_after_reset", {62'd0, ACK_FX, BUSY}, 64'd0);

        // Randomised conversions across the full range of magnitudes.
        for (int i = 0; i < 2000; i++) begin
            fx = $urandom;
            if ($urandom_range(0, 1) == 1) fx = fx >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) fx = -fx;
            conv(fx, ref_float(fx), ref_lat(fx), int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
